// File: rtl/PKG_pwm.sv
// Shared PWM type definitions used by the carrier generator and its consumers.
package PKG_pwm;

  typedef enum logic [1:0] {
    NO_COUNT     = 2'd0,
    COUNT_UP     = 2'd1,
    COUNT_DOWN   = 2'd2,
    COUNT_UPDOWN = 2'd3
  } _count_mode;

  typedef enum logic {
    PWM_OFF = 1'b0,
    PWM_ON  = 1'b1
  } _pwm_onoff;

endpackage

// File: rtl/pwm_compare_dt.sv
// Carrier comparator with shadow-buffered compare value and dead-time insertion,
// driving one complementary high/low gate pair.
module pwm_compare_dt
  import PKG_pwm::*;
#(
  parameter int unsigned CW  = 16,
  parameter int unsigned DTW = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [CW-1:0]  carrier,
  input  logic [CW-1:0]  period,
  input  logic [CW-1:0]  compare,
  input  logic [1:0]     update_mode,
  input  logic [DTW-1:0] deadtime,
  input  _count_mode     count_mode,
  input  _pwm_onoff      pwm_onoff,
  output logic           pwm_h,
  output logic           pwm_l,
  output logic [CW-1:0]  compare_active,
  output logic           zero_evt,
  output logic           peak_evt
);

  typedef enum logic [2:0] {
    StOff = 3'd0,
    StDtH = 3'd1,
    StHOn = 3'd2,
    StDtL = 3'd3,
    StLOn = 3'd4
  } state_e;

  state_e         state_q, state_d;
  logic [DTW-1:0] dt_cnt_q, dt_cnt_d;
  logic           pwm_h_q, pwm_h_d;
  logic           pwm_l_q, pwm_l_d;
  logic [CW-1:0]  carrier_q;
  logic [CW-1:0]  compare_active_q, compare_active_d;
  logic           zero_evt_q, zero_evt_d;
  logic           peak_evt_q, peak_evt_d;
  logic           cmp_q, cmp_d;

  logic           enable;
  logic [CW-1:0]  period_m1;
  logic           zero_cond;
  logic           peak_cond;
  logic           load;

  // Event detection and shadow load
  always_comb begin
    enable    = (pwm_onoff == PWM_ON) && (count_mode != NO_COUNT) && (period != '0);
    period_m1 = period - CW'(1);
    zero_cond = (carrier == '0) && (carrier_q != '0);
    peak_cond = (carrier >= period_m1) && (carrier_q < period_m1);

    unique case (update_mode)
      2'd0:    load = zero_cond;
      2'd1:    load = peak_cond;
      2'd2:    load = zero_cond || peak_cond;
      default: load = 1'b1;
    endcase

    zero_evt_d       = zero_cond;
    peak_evt_d       = peak_cond;
    compare_active_d = load ? compare : compare_active_q;
    // Uses the compare value in force before this edge's shadow load.
    cmp_d            = enable && (carrier < compare_active_q);
  end

  // Dead-time state machine
  always_comb begin
    state_d  = state_q;
    dt_cnt_d = dt_cnt_q;
    pwm_h_d  = pwm_h_q;
    pwm_l_d  = pwm_l_q;

    if (!enable) begin
      state_d = StOff;
      pwm_h_d = 1'b0;
      pwm_l_d = 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          pwm_h_d  = 1'b0;
          pwm_l_d  = 1'b0;
          dt_cnt_d = deadtime;
          state_d  = cmp_q ? StDtH : StDtL;
        end

        StDtH: begin
          pwm_h_d = 1'b0;
          pwm_l_d = 1'b0;
          if (!cmp_q) begin
            dt_cnt_d = deadtime;
            state_d  = StDtL;
          end else if (dt_cnt_q == '0) begin
            pwm_h_d = 1'b1;
            state_d = StHOn;
          end else begin
            dt_cnt_d = dt_cnt_q - DTW'(1);
          end
        end

        StDtL: begin
          pwm_h_d = 1'b0;
          pwm_l_d = 1'b0;
          if (cmp_q) begin
            dt_cnt_d = deadtime;
            state_d  = StDtH;
          end else if (dt_cnt_q == '0) begin
            pwm_l_d = 1'b1;
            state_d = StLOn;
          end else begin
            dt_cnt_d = dt_cnt_q - DTW'(1);
          end
        end

        StHOn: begin
          pwm_l_d = 1'b0;
          if (!cmp_q) begin
            pwm_h_d  = 1'b0;
            dt_cnt_d = deadtime;
            state_d  = StDtL;
          end
        end

        StLOn: begin
          pwm_h_d = 1'b0;
          if (cmp_q) begin
            pwm_l_d  = 1'b0;
            dt_cnt_d = deadtime;
            state_d  = StDtH;
          end
        end

        default: begin
          pwm_h_d = 1'b0;
          pwm_l_d = 1'b0;
          state_d = StOff;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= StOff;
      dt_cnt_q         <= '0;
      pwm_h_q          <= 1'b0;
      pwm_l_q          <= 1'b0;
      carrier_q        <= '0;
      compare_active_q <= '0;
      zero_evt_q       <= 1'b0;
      peak_evt_q       <= 1'b0;
      cmp_q            <= 1'b0;
    end else begin
      state_q          <= state_d;
      dt_cnt_q         <= dt_cnt_d;
      pwm_h_q          <= pwm_h_d;
      pwm_l_q          <= pwm_l_d;
      carrier_q        <= carrier;
      compare_active_q <= compare_active_d;
      zero_evt_q       <= zero_evt_d;
      peak_evt_q       <= peak_evt_d;
      cmp_q            <= cmp_d;
    end
  end

  assign pwm_h          = pwm_h_q;
  assign pwm_l          = pwm_l_q;
  assign compare_active = compare_active_q;
  assign zero_evt       = zero_evt_q;
  assign peak_evt       = peak_evt_q;

  // Shoot-through guard: the gate pair must never be driven high together.
  assert property (@(posedge clk) disable iff (!reset) !(pwm_h_q && pwm_l_q));

endmodule

// File: tb/tb_pwm_compare_dt.sv
// Scoreboard bench for pwm_compare_dt: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them.
module tb_pwm_compare_dt;
  import PKG_pwm::*;

  localparam int CW  = 16;
  localparam int DTW = 10;

  localparam int SigH    = 0;
  localparam int SigL    = 1;
  localparam int SigZero = 2;
  localparam int SigPeak = 3;
  localparam int SigCa   = 4;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [CW-1:0]  carrier = '0;
  logic [CW-1:0]  period = '0;
  logic [CW-1:0]  compare = '0;
  logic [1:0]     update_mode = '0;
  logic [DTW-1:0] deadtime = '0;
  _count_mode     count_mode = NO_COUNT;
  _pwm_onoff      pwm_onoff = PWM_OFF;
  logic           pwm_h;
  logic           pwm_l;
  logic [CW-1:0]  compare_active;
  logic           zero_evt;
  logic           peak_evt;

  pwm_compare_dt #(
    .CW (CW),
    .DTW(DTW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .carrier       (carrier),
    .period        (period),
    .compare       (compare),
    .update_mode   (update_mode),
    .deadtime      (deadtime),
    .count_mode    (count_mode),
    .pwm_onoff     (pwm_onoff),
    .pwm_h         (pwm_h),
    .pwm_l         (pwm_l),
    .compare_active(compare_active),
    .zero_evt      (zero_evt),
    .peak_evt      (peak_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] sample(input int s);
    case (s)
      SigH:    return 32'(pwm_h);
      SigL:    return 32'(pwm_l);
      SigZero: return 32'(zero_evt);
      SigPeak: return 32'(peak_evt);
      SigCa:   return 32'(compare_active);
      default: return '1;
    endcase
  endfunction

  function automatic string sig_name(input int s);
    case (s)
      SigH:    return "pwm_h";
      SigL:    return "pwm_l";
      SigZero: return "zero_evt";
      SigPeak: return "peak_evt";
      SigCa:   return "compare_active";
      default: return "unknown";
    endcase
  endfunction

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, c, act, exp);
  endtask

  task automatic push(input int sig, input int c, input logic [31:0] v);
    exp_t e;
    e.cyc = c;
    e.sig = sig;
    e.val = v;
    sb.push_back(e);
  endtask

  // Monitor: every cycle check gate exclusivity and any expectations due now.
  always @(negedge clk) begin
    check("no_overlap", cyc, 32'(pwm_h & pwm_l), 32'd0);
    for (int j = sb.size() - 1; j >= 0; j--) begin
      if (sb[j].cyc <= cyc) begin
        if (sb[j].cyc < cyc) check({"stale_", sig_name(sb[j].sig)}, sb[j].cyc, 32'd1, 32'd0);
        else check(sig_name(sb[j].sig), cyc, sample(sb[j].sig), sb[j].val);
        sb.delete(j);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Applies reset with the given configuration; carrier i of the following
  // loop is sampled at edge base+1+i.
  task automatic start(input logic [CW-1:0] per, input logic [CW-1:0] cmpv,
                       input logic [1:0] mode, input logic [DTW-1:0] dt,
                       input _count_mode cm, output int base);
    @(negedge clk);
    #2;
    reset       = 1'b0;
    period      = per;
    compare     = cmpv;
    update_mode = mode;
    deadtime    = dt;
    count_mode  = cm;
    pwm_onoff   = PWM_ON;
    carrier     = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    base  = cyc;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    int m;

    // Reset state
    @(negedge clk);
    #2;
    check("reset_h", cyc, 32'(pwm_h), 32'd0);
    check("reset_l", cyc, 32'(pwm_l), 32'd0);
    check("reset_ca", cyc, 32'(compare_active), 32'd0);
    check("reset_evt", cyc, 32'({zero_evt, peak_evt}), 32'd0);

    // Up ramp, compare 40, zero-event load, dead time 5
    start(16'd100, 16'd40, 2'd0, 10'd5, COUNT_UP, base);
    for (int e = 1; e <= 260; e++) begin
      push(SigH, base + e, 32'((e >= 109 && e <= 141) || (e >= 208 && e <= 241)));
      push(SigL, base + e, 32'((e >= 7 && e <= 102) || (e >= 148 && e <= 201) || e >= 248));
      push(SigZero, base + e, 32'(e == 101 || e == 201));
      push(SigPeak, base + e, 32'(e == 100 || e == 200));
      push(SigCa, base + e, (e <= 100) ? 32'd0 : 32'd40);
    end
    for (int i = 0; i < 260; i++) begin
      carrier = CW'(i % 100);
      tick();
    end

    // Up/down triangle, peak-event load, compare rewritten on the down slope
    start(16'd100, 16'd40, 2'd1, 10'd5, COUNT_UPDOWN, base);
    for (int e = 1; e <= 320; e++) begin
      push(SigZero, base + e, 32'(e == 199));
      push(SigPeak, base + e, 32'(e == 100 || e == 298));
      push(SigCa, base + e, (e <= 99) ? 32'd0 : ((e <= 297) ? 32'd40 : 32'd60));
    end
    for (int i = 0; i < 320; i++) begin
      m = i % 198;
      carrier = CW'((m <= 99) ? m : 198 - m);
      if (i == 150) compare = 16'd60;
      tick();
    end

    // Zero dead time, compare 50, immediate load
    start(16'd100, 16'd50, 2'd3, 10'd0, COUNT_UP, base);
    for (int e = 1; e <= 111; e++) begin
      push(SigH, base + e, 32'((e >= 4 && e <= 51) || e >= 103));
      push(SigL, base + e, 32'(e == 2 || (e >= 53 && e <= 101)));
      push(SigCa, base + e, 32'd50);
    end
    for (int i = 0; i < 111; i++) begin
      carrier = CW'(i % 100);
      tick();
    end

    // Dead time 10 absorbs a 3-cycle compare pulse
    start(16'd100, 16'd0, 2'd3, 10'd10, COUNT_UP, base);
    for (int e = 1; e <= 45; e++) begin
      push(SigH, base + e, 32'd0);
      push(SigL, base + e, 32'((e >= 12 && e <= 22) || e >= 37));
      push(SigCa, base + e, (e >= 21 && e <= 23) ? 32'd30 : 32'd0);
    end
    for (int i = 0; i < 45; i++) begin
      carrier = 16'd20;
      compare = (i >= 20 && i <= 22) ? 16'd30 : 16'd0;
      tick();
    end

    // Disable while high, then re-enable
    start(16'd100, 16'd50, 2'd3, 10'd3, COUNT_UP, base);
    for (int e = 1; e <= 30; e++) begin
      push(SigH, base + e, 32'((e >= 7 && e <= 15) || e >= 24));
      push(SigL, base + e, 32'd0);
    end
    for (int i = 0; i < 30; i++) begin
      carrier   = 16'd20;
      pwm_onoff = (i >= 15 && i <= 17) ? PWM_OFF : PWM_ON;
      tick();
    end

    // period=0, then NO_COUNT: gates held low, shadow still loads
    start(16'd0, 16'd50, 2'd3, 10'd0, COUNT_UP, base);
    for (int e = 1; e <= 20; e++) begin
      push(SigH, base + e, 32'd0);
      push(SigL, base + e, 32'd0);
      push(SigCa, base + e, 32'd50);
    end
    for (int i = 0; i < 20; i++) begin
      carrier    = 16'd20;
      period     = (i < 10) ? 16'd0 : 16'd100;
      count_mode = (i < 10) ? COUNT_UP : NO_COUNT;
      tick();
    end

    // compare=0: low side permanently on after the dead time
    start(16'd100, 16'd0, 2'd3, 10'd4, COUNT_UP, base);
    for (int e = 1; e <= 60; e++) begin
      push(SigH, base + e, 32'd0);
      push(SigL, base + e, 32'(e >= 6));
    end
    for (int i = 0; i < 60; i++) begin
      carrier = CW'(i % 100);
      tick();
    end

    // compare=period: high side on for the whole carrier range
    start(16'd100, 16'd100, 2'd3, 10'd0, COUNT_UP, base);
    for (int e = 1; e <= 210; e++) begin
      push(SigH, base + e, 32'(e >= 4));
      push(SigL, base + e, 32'(e == 2));
    end
    for (int i = 0; i < 210; i++) begin
      carrier = CW'(i % 100);
      tick();
    end

    // Asynchronous reset mid-period, away from any clock edge
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    check("async_h", cyc, 32'(pwm_h), 32'd0);
    check("async_l", cyc, 32'(pwm_l), 32'd0);
    check("async_ca", cyc, 32'(compare_active), 32'd0);
    check("async_evt", cyc, 32'({zero_evt, peak_evt}), 32'd0);

    repeat (2) @(negedge clk);
    check("sb_drained", cyc, 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
